// File: rtl/mem_master_pkg.sv
// rtl/mem_master_pkg.sv - shared state encoding and default widths for mem_word_master
package mem_master_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int BYTE_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_t;

endpackage

// File: rtl/mem_word_master.sv
// rtl/mem_word_master.sv - 16-bit word requests to two little-endian byte RAM accesses
// Optional single-byte access mode: MEM_WORD_MASTER_BYTE_ACCESS_EN
module mem_word_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int BYTE_W = BYTE_W_DEFAULT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic                ReqWrite,
`ifdef MEM_WORD_MASTER_BYTE_ACCESS_EN
  input  logic                ReqByte,
`endif
  input  logic [ADDR_W-1:0]   ReqAddr,
  input  logic [2*BYTE_W-1:0] ReqWData,
  output logic                RspValid,
  output logic [2*BYTE_W-1:0] RspRData,
  output logic [ADDR_W-1:0]   MemAddress,
  output logic [BYTE_W-1:0]   MemData,
  output logic                MemWR,
  output logic                MemCS,
  input  logic [BYTE_W-1:0]   MemOut
);

  state_t state, state_next;

  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [2*BYTE_W-1:0] lat_wdata;
  logic [BYTE_W-1:0]   rdata_lo;
  logic                is_byte;

`ifdef MEM_WORD_MASTER_BYTE_ACCESS_EN
  logic lat_byte;
  assign is_byte = lat_byte;
`else
  assign is_byte = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Memory-side outputs depend only on state and latched request fields.
  always_comb begin
    state_next = state;
    ReqReady   = 1'b0;
    MemCS      = 1'b1;
    MemWR      = 1'b0;
    MemAddress = '0;
    MemData    = '0;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) state_next = BYTE0;
      end
      BYTE0: begin
        MemCS      = 1'b0;
        MemWR      = lat_write;
        MemAddress = lat_addr;
        if (lat_write) MemData = lat_wdata[BYTE_W-1:0];
        state_next = is_byte ? IDLE : BYTE1;
      end
      BYTE1: begin
        MemCS      = 1'b0;
        MemWR      = lat_write;
        MemAddress = lat_addr + ADDR_W'(1);
        if (lat_write) MemData = lat_wdata[2*BYTE_W-1:BYTE_W];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_lo  <= '0;
      RspValid  <= 1'b0;
      RspRData  <= '0;
`ifdef MEM_WORD_MASTER_BYTE_ACCESS_EN
      lat_byte  <= 1'b0;
`endif
    end else begin
      RspValid <= (state == BYTE1) || ((state == BYTE0) && is_byte);
      if ((state == IDLE) && ReqValid) begin
        lat_write <= ReqWrite;
        lat_addr  <= ReqAddr;
        lat_wdata <= ReqWData;
`ifdef MEM_WORD_MASTER_BYTE_ACCESS_EN
        lat_byte  <= ReqByte;
`endif
      end
      // Low byte is staged so RspRData keeps the previous word until this read completes.
      if ((state == BYTE0) && !lat_write) begin
        if (is_byte) RspRData <= {{BYTE_W{1'b0}}, MemOut};
        else         rdata_lo <= MemOut;
      end
      if ((state == BYTE1) && !lat_write) RspRData <= {MemOut, rdata_lo};
    end
  end

endmodule

// File: tb/tb_mem_word_master.sv
// tb/tb_mem_word_master.sv - directed vector bench for mem_word_master with a byte RAM model
module tb_mem_word_master;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [15:0] ReqAddr;
  logic [15:0] ReqWData;
  logic        RspValid;
  logic [15:0] RspRData;
  logic [15:0] MemAddress;
  logic [7:0]  MemData;
  logic        MemWR;
  logic        MemCS;
  logic [7:0]  MemOut;
`ifdef MEM_WORD_MASTER_BYTE_ACCESS_EN
  logic        ReqByte;
`endif

  logic [7:0] ram [0:65535];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  mem_word_master dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
`ifdef MEM_WORD_MASTER_BYTE_ACCESS_EN
    .ReqByte    (ReqByte),
`endif
    .ReqAddr    (ReqAddr),
    .ReqWData   (ReqWData),
    .RspValid   (RspValid),
    .RspRData   (RspRData),
    .MemAddress (MemAddress),
    .MemData    (MemData),
    .MemWR      (MemWR),
    .MemCS      (MemCS),
    .MemOut     (MemOut)
  );

  always @(posedge Clock) if (!MemCS && MemWR) ram[MemAddress] <= MemData;
  assign MemOut = MemCS ? 8'hxx : ram[MemAddress];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_req(input vec_t v);
    logic [15:0] a1;
    a1 = v.addr + 16'd1;
    ReqValid = 1'b1;
    ReqWrite = v.wr;
    ReqAddr  = v.addr;
    ReqWData = v.wdata;
    check("idle_ready", {31'd0, ReqReady}, 32'd1);
    step();
    ReqValid = 1'b0;
    ReqAddr  = 16'h5555;
    ReqWData = 16'h0000;
    check("b0_cs", {31'd0, MemCS}, 32'd0);
    check("b0_addr", {16'd0, MemAddress}, {16'd0, v.addr});
    check("b0_wr", {31'd0, MemWR}, {31'd0, v.wr});
    check("b0_data", {24'd0, MemData}, v.wr ? {24'd0, v.wdata[7:0]} : 32'd0);
    check("b0_ready", {31'd0, ReqReady}, 32'd0);
    step();
    check("b1_addr", {16'd0, MemAddress}, {16'd0, a1});
    check("b1_wr", {31'd0, MemWR}, {31'd0, v.wr});
    check("b1_data", {24'd0, MemData}, v.wr ? {24'd0, v.wdata[15:8]} : 32'd0);
    check("b1_rspvalid", {31'd0, RspValid}, 32'd0);
    step();
    check("rsp_valid", {31'd0, RspValid}, 32'd1);
    check("rsp_rdata", {16'd0, RspRData}, {16'd0, v.exp_rdata});
    check("rsp_cs", {31'd0, MemCS}, 32'd1);
    if (v.wr) begin
      check("ram_lo", {24'd0, ram[v.addr]}, {24'd0, v.wdata[7:0]});
      check("ram_hi", {24'd0, ram[a1]}, {24'd0, v.wdata[15:8]});
    end
    step();
    check("rsp_pulse_end", {31'd0, RspValid}, 32'd0);
    check("rdata_hold", {16'd0, RspRData}, {16'd0, v.exp_rdata});
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234};
    vecs[3] = '{1'b1, 16'hFFFF, 16'hA55A, 16'h1234};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'hA55A};
    vecs[5] = '{1'b1, 16'h0100, 16'h1357, 16'hA55A};
    vecs[6] = '{1'b0, 16'h0100, 16'h0000, 16'h1357};

    ram[16'hFFFF] = 8'h34;
    ram[16'h0000] = 8'h12;
    ram[16'h0200] = 8'h00;
    ram[16'h0201] = 8'h00;
    ram[16'h0300] = 8'h66;
    ram[16'h0301] = 8'h77;

    Reset    = 1'b1;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqAddr  = 16'h0000;
    ReqWData = 16'h0000;
`ifdef MEM_WORD_MASTER_BYTE_ACCESS_EN
    ReqByte  = 1'b0;
`endif
    step();
    step();
    Reset = 1'b0;
    check("rst_ready", {31'd0, ReqReady}, 32'd1);
    check("rst_rspvalid", {31'd0, RspValid}, 32'd0);
    check("rst_rdata", {16'd0, RspRData}, 32'd0);
    check("rst_cs", {31'd0, MemCS}, 32'd1);
    check("rst_wr", {31'd0, MemWR}, 32'd0);
    check("rst_addr", {16'd0, MemAddress}, 32'd0);
    check("rst_data", {24'd0, MemData}, 32'd0);

    for (int i = 0; i < 7; i++) run_req(vecs[i]);

    // Back-to-back reads with ReqValid held high.
    ReqValid = 1'b1;
    ReqWrite = 1'b0;
    ReqAddr  = 16'h0010;
    step();
    ReqAddr = 16'h0100;
    check("b2b_ready_n1", {31'd0, ReqReady}, 32'd0);
    step();
    check("b2b_ready_n2", {31'd0, ReqReady}, 32'd0);
    check("b2b_addr_n2", {16'd0, MemAddress}, 32'h0011);
    step();
    check("b2b_rsp_n3", {31'd0, RspValid}, 32'd1);
    check("b2b_rdata_n3", {16'd0, RspRData}, 32'hBEEF);
    check("b2b_ready_n3", {31'd0, ReqReady}, 32'd1);
    step();
    ReqValid = 1'b0;
    check("b2b_ready_n4", {31'd0, ReqReady}, 32'd0);
    check("b2b_addr_n4", {16'd0, MemAddress}, 32'h0100);
    check("b2b_rsp_n4", {31'd0, RspValid}, 32'd0);
    step();
    check("b2b_ready_n5", {31'd0, ReqReady}, 32'd0);
    step();
    check("b2b_rsp_n6", {31'd0, RspValid}, 32'd1);
    check("b2b_rdata_n6", {16'd0, RspRData}, 32'h1357);
    step();

    // Reset during BYTE1 of a write.
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    ReqAddr  = 16'h0200;
    ReqWData = 16'hCAFE;
    step();
    ReqValid = 1'b0;
    step();
    check("rstmid_b1_addr", {16'd0, MemAddress}, 32'h0201);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rstmid_rsp", {31'd0, RspValid}, 32'd0);
    check("rstmid_cs", {31'd0, MemCS}, 32'd1);
    check("rstmid_ready", {31'd0, ReqReady}, 32'd1);
    check("rstmid_ram_lo", {24'd0, ram[16'h0200]}, 32'hFE);
    check("rstmid_ram_hi", {24'd0, ram[16'h0201]}, 32'hCA);
    step();
    check("rstmid_rsp_after", {31'd0, RspValid}, 32'd0);

`ifdef MEM_WORD_MASTER_BYTE_ACCESS_EN
    ReqValid = 1'b1;
    ReqByte  = 1'b1;
    ReqWrite = 1'b0;
    ReqAddr  = 16'h0010;
    step();
    ReqValid = 1'b0;
    check("byte_rd_cs", {31'd0, MemCS}, 32'd0);
    check("byte_rd_addr", {16'd0, MemAddress}, 32'h0010);
    step();
    check("byte_rd_rsp", {31'd0, RspValid}, 32'd1);
    check("byte_rd_rdata", {16'd0, RspRData}, 32'h00EF);
    check("byte_rd_cs_done", {31'd0, MemCS}, 32'd1);
    check("byte_rd_ready", {31'd0, ReqReady}, 32'd1);
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    ReqAddr  = 16'h0300;
    ReqWData = 16'h12AB;
    step();
    ReqValid = 1'b0;
    check("byte_wr_data", {24'd0, MemData}, 32'hAB);
    step();
    check("byte_wr_rsp", {31'd0, RspValid}, 32'd1);
    check("byte_wr_rdata", {16'd0, RspRData}, 32'h00EF);
    check("byte_wr_ram_lo", {24'd0, ram[16'h0300]}, 32'hAB);
    check("byte_wr_ram_hi", {24'd0, ram[16'h0301]}, 32'h77);
    ReqByte = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_word_master.md
Name: mem_word_master

Overview:
- Bus initiator that drives the 8-bit byte-wide RAM port: Address, Data, WR (1 = write), CS (active-low), read data MemOut.
- Converts 16-bit word read/write requests from the CPU datapath into two consecutive byte accesses.
- Byte order is little-endian: low byte at A, high byte at A+1.
- Sits between the instruction-fetch/load-store control and the RAM.

Parameters:
- ADDR_W, 16, width of request and memory addresses.
- BYTE_W, 8, memory data width; word width is 2*BYTE_W.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request this cycle.
- ReqWrite  in  1  1 = word write, 0 = word read.
- ReqAddr  in  ADDR_W  word start address A.
- ReqWData  in  2*BYTE_W  write data.
- RspValid  out  1  one-cycle pulse: access complete.
- RspRData  out  2*BYTE_W  read data; valid while RspValid = 1.
- MemAddress  out  ADDR_W  to RAM Address.
- MemData  out  BYTE_W  to RAM Data.
- MemWR  out  1  to RAM WR.
- MemCS  out  1  to RAM CS (0 = selected).
- MemOut  in  BYTE_W  from RAM; high-Z when RAM is not selected.

Behaviour:
- Clock and reset: single clock domain (Clock). Reset is synchronous and active-high (Reset).
- Reset values:
  - state IDLE, ReqReady = 1, RspValid = 0, RspRData = 0.
  - MemCS = 1, MemWR = 0, MemAddress = 0, MemData = 0.
- Output timing:
  - Memory-side outputs decode only from registered state and latched request registers.
  - No combinational path from Req* inputs to Mem* outputs.
- IDLE:
  - ReqReady = 1, MemCS = 1, MemWR = 0.
  - On ReqValid (edge of cycle N): latch ReqWrite, ReqAddr, ReqWData, then go to BYTE0.
- BYTE0 (cycle N+1):
  - MemCS = 0, MemAddress = A, MemWR = latched write.
  - Write: MemData = WData[7:0]; the RAM commits it at the closing edge.
  - Read: sample MemOut into RData[7:0] at the closing edge.
  - Next state BYTE1.
- BYTE1 (cycle N+2):
  - Same as BYTE0 with MemAddress = A+1 (mod 2^ADDR_W: FFFF wraps to 0000) and byte [15:8].
  - Next state IDLE.
- Response:
  - RspValid = 1 for exactly cycle N+3, both reads and writes.
  - RspRData holds the assembled word from N+3 until the next read completes.
  - Writes leave RspRData unchanged.
- ReqReady = 0 in BYTE0/BYTE1; ReqValid is ignored there.
- Throughput:
  - A request presented in cycle N+3 is accepted at once; RspValid and ReqReady may both be 1 in the same cycle.
  - Sustained rate: one word every 3 cycles.
- MemOut handling: never sampled outside read byte states; X/Z on MemOut at other times has no effect.
- Reset mid-operation:
  - At the edge where Reset = 1, the state goes to IDLE and no RspValid is issued.
  - A write byte already driven during that cycle is still committed by the RAM at that same edge.
  - MemCS = 1 from the next cycle.
- MemData is 0 during read and IDLE cycles.

Optional Feature:
- Macro: MEM_WORD_MASTER_BYTE_ACCESS_EN.
- With the macro defined:
  - Adds input port ReqByte (1 bit), latched with the request.
  - ReqByte = 1 performs BYTE0 only, then returns to IDLE; RspValid follows in cycle N+2.
  - Read result is zero-extended: RspRData = {8'h00, byte}.
  - Write uses ReqWData[7:0] only.
- Without the macro: the port is absent and every access is a word access.

Decomposition:
- Package mem_master_pkg contains:
  - state enum {IDLE, BYTE0, BYTE1}.
  - localparams ADDR_W_DEFAULT = 16, BYTE_W_DEFAULT = 8.
- No sub-module: the FSM, address increment and byte mux stay in one module.

Test Plan:
- Word write: ReqValid, ReqWrite = 1, A = 16'h0010, WData = 16'hBEEF at cycle N.
  - N+1: MemAddress 0010, MemData EF, MemWR 1, MemCS 0.
  - N+2: 0011 / BE.
  - N+3: RspValid = 1; RAM[0010] = EF, RAM[0011] = BE.
- Word read of 0010 after the write → RspValid at N+3 with RspRData = 16'hBEEF; MemWR = 0 throughout.
- Wrap: read A = 16'hFFFF with RAM[FFFF] = 34, RAM[0000] = 12 → byte addresses FFFF then 0000; RspRData = 16'h1234.
- Back-to-back: ReqValid held high for two reads → second accepted in cycle N+3; responses at N+3 and N+6; ReqReady low at N+1, N+2, N+4, N+5.
- Reset asserted in BYTE1 of a write → RAM[A+1] is updated; no RspValid; MemCS = 1 and ReqReady = 1 on the following cycle.
- Byte mode (MEM_WORD_MASTER_BYTE_ACCESS_EN, ReqByte = 1): read A = 0010 → only one memory cycle; RspValid at N+2, RspRData = 16'h00EF.
